gauss_pe_vec: RTL and testbench
===============================

// Module: gauss_pe_vec
// PURPOSE
// Vectorised, registered Gaussian-elimination / MAC processing element over GF(2^GF_BIT), LANES elements per beat.
// Successor to the scalar systolic PE: one element of the elimination/MAC array, chained row-wise.
// Adds valid/stall flow control, async reset and pivot-row tracking with singular detection.
// A pivot_mode=1 instance heads each row of the array; pivot_mode=0 instances eliminate.
// PARAMETERS
// GF_BIT       4   field width, 4 or 8 only
// LANES        4   GF elements processed per beat
// OP_CODE_LEN  4   opcode width
// TOWER        0   0: AES-polynomial field (x^4+x+1 / x^8+x^4+x^3+x+1), 1: tower field
// ROW_W        6   row counter / pivot_row width
// PORTS
// clk          in   1               rising-edge clock
// rst_n        in   1               asynchronous, active-low reset
// en           in   1               global advance; 0 = every register holds
// pivot_mode   in   1               static: 1 = pivot PE, 0 = elimination PE
// valid_in     in   1               beat qualifier for all *_in sidebands
// valid_out    out  1               registered valid_in
// start_in/out      1               start of elimination pass (out = registered in)
// finish_in/out     1               end of pass (out = registered in)
// op_in/out         OP_CODE_LEN     opcode (out = registered in)
// gauss_op_in/out   2               gauss sub-op; out computed in pivot mode, else registered in
// data_in/out       LANES*GF_BIT    row chunk, lane i = bits [i*GF_BIT +: GF_BIT]
// dataA_in/out      LANES*GF_BIT    MAC operand / shift chain
// dataB_in/out      GF_BIT          broadcast factor
// key_in       in   LANES*GF_BIT    key operand
// r            out  LANES*GF_BIT    accumulator/stored-row registers
// pivot_row    out  ROW_W           row index of first non-zero pivot
// singular     out  1               sticky: pass finished without a pivot
// BEHAVIOUR
// - rst_n=0 (async): every register and output = 0. Release is sync to clk.
// - en=0: all state holds. en=1,valid_in=0: valid_out<=0; r, data_out and flags hold.
// - start/finish are only sampled when valid_in=1. All outputs are registered: latency 1 beat.
// - Invalid GF_BIT elaborates $error. inv(0) is defined as 0.
// - Default: dataA_out<=dataA_in; dataB_out<=dataB_in.
// - OP 3: r_i<=key_i.
// - OP 4 SHIFT: r<=dataA_in; dataA_out<=old r.
// - OP 6: r_i<=r_i^dataB*dataA_i.
// - OP 7: r_i<=r_i^key_i*dataA_i.
// - Other ops except 1: r holds and data_out<=data_in.
// - OP 1, pivot_mode=1 (d0 = lane 0 of data_in; state piv_found, row_cnt):
//   start: piv_found<=0, row_cnt<=0, singular<=0, r<=0, gauss_op_out<=00, dataB_out<=0.
//   d0!=0 and !piv_found: piv_found<=1, pivot_row<=row_cnt, r lane0<=d0, gauss_op_out<=01, dataB_out<=inv(d0).
//   piv_found: gauss_op_out<=10, dataB_out<=d0.
//   d0==0 and !piv_found: gauss_op_out<=00, dataB_out<=0.
//   row_cnt increments per non-start/non-finish row and saturates at all-ones.
//   finish: gauss_op_out<=11, singular<=!piv_found (sticky until next start).
//   start&finish together: clear, then singular<=1 and gauss_op_out<=11.
//   data_out<=data_in (pass) in all pivot-mode cases.
// - OP 1, pivot_mode=0, per lane i:
//   start: r_i<=0, data_out_i<=0.
//   00: data_out_i<=data_in_i.
//   01: r_i<=dataB*data_in_i; data_out_i<=old r_i.
//   10: data_out_i<=data_in_i^dataB*r_i.
//   11: data_out_i<=r_i; r_i<=0.
// TESTING (GF16 AES unless noted)
// - Async reset while OP6 accumulates, asserted between edges -> all outputs 0 immediately, before the next clk edge.
// - Pivot PE: start, d0=0,2,3, then finish -> gauss_op_out 00,00,01,10,11; dataB_out 0,0,9,3,-; pivot_row=1; singular=0.
// - Elim PE: 01 with dataB=1, data=[1,2,3,4]; then 10 with dataB=3, data=0 -> r=[1,2,3,4], data_out=[3,6,5,C].
// - OP6 from r=0 with dataB=2, dataA=[9,1,0,8] -> r=[1,2,0,3]. Then en=0 for 3 cycles -> all outputs frozen.
// - Pivot PE: start, 4 rows d0=0, finish -> singular=1, pivot_row=0. Then start -> singular=0.
// - GF_BIT=8, LANES=1, TOWER=0: pivot d0=0x53 -> dataB_out=0xCA.

Source files
------------

// File: rtl/gauss_pe_vec.sv
// Vectorised GF(2^GF_BIT) Gaussian-elimination / MAC processing element; all outputs registered, 1-beat latency.
// No backpressure: en=0 freezes every register, valid_in=0 drops valid_out and holds datapath/pivot state.
module gauss_pe_vec #(
    parameter int GF_BIT      = 4,
    parameter int LANES       = 4,
    parameter int OP_CODE_LEN = 4,
    parameter int TOWER       = 0,
    parameter int ROW_W       = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      pivot_mode,
    input  logic                      valid_in,
    output logic                      valid_out,
    input  logic                      start_in,
    output logic                      start_out,
    input  logic                      finish_in,
    output logic                      finish_out,
    input  logic [OP_CODE_LEN-1:0]    op_in,
    output logic [OP_CODE_LEN-1:0]    op_out,
    input  logic [1:0]                gauss_op_in,
    output logic [1:0]                gauss_op_out,
    input  logic [LANES*GF_BIT-1:0]   data_in,
    output logic [LANES*GF_BIT-1:0]   data_out,
    input  logic [LANES*GF_BIT-1:0]   dataA_in,
    output logic [LANES*GF_BIT-1:0]   dataA_out,
    input  logic [GF_BIT-1:0]         dataB_in,
    output logic [GF_BIT-1:0]         dataB_out,
    input  logic [LANES*GF_BIT-1:0]   key_in,
    output logic [LANES*GF_BIT-1:0]   r,
    output logic [ROW_W-1:0]          pivot_row,
    output logic                      singular
);

    generate
        if (GF_BIT != 4 && GF_BIT != 8) begin : g_bad_gf_bit
            $error("gauss_pe_vec: GF_BIT must be 4 or 8");
        end
    endgenerate

    localparam logic [OP_CODE_LEN-1:0] OP_GAUSS = OP_CODE_LEN'(1);
    localparam logic [OP_CODE_LEN-1:0] OP_KEY   = OP_CODE_LEN'(3);
    localparam logic [OP_CODE_LEN-1:0] OP_SHIFT = OP_CODE_LEN'(4);
    localparam logic [OP_CODE_LEN-1:0] OP_MACB  = OP_CODE_LEN'(6);
    localparam logic [OP_CODE_LEN-1:0] OP_MACK  = OP_CODE_LEN'(7);
    // Low bits of x^4+x+1 / x^8+x^4+x^3+x+1, folded back in on overflow
    localparam logic [GF_BIT-1:0] POLY_LO = GF_BIT'((GF_BIT == 8) ? 27 : 3);

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        return {a[1] & b[1] ^ a[1] & b[0] ^ a[0] & b[1], a[0] & b[0] ^ a[1] & b[1]};
    endfunction

    // GF(16) = GF(4)[y]/(y^2 + y + w), w = 2'b10
    function automatic logic [3:0] t16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, hl, lh, ll;
        hh = gf4_mul(a[3:2], b[3:2]);
        hl = gf4_mul(a[3:2], b[1:0]);
        lh = gf4_mul(a[1:0], b[3:2]);
        ll = gf4_mul(a[1:0], b[1:0]);
        return {hh ^ hl ^ lh, ll ^ gf4_mul(hh, 2'b10)};
    endfunction

    // GF(256) = GF(16)[z]/(z^2 + z + w*y), w*y = 4'h8 has trace 1 so the quadratic is irreducible
    function automatic logic [7:0] t256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh, hl, lh, ll;
        hh = t16_mul(a[7:4], b[7:4]);
        hl = t16_mul(a[7:4], b[3:0]);
        lh = t16_mul(a[3:0], b[7:4]);
        ll = t16_mul(a[3:0], b[3:0]);
        return {hh ^ hl ^ lh, ll ^ t16_mul(hh, 4'h8)};
    endfunction

    function automatic logic [GF_BIT-1:0] aes_mul(input logic [GF_BIT-1:0] a, input logic [GF_BIT-1:0] b);
        logic [GF_BIT-1:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < GF_BIT; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[GF_BIT-2:0], 1'b0} ^ (aa[GF_BIT-1] ? POLY_LO : '0);
        end
        return p;
    endfunction

    function automatic logic [GF_BIT-1:0] gf_mul(input logic [GF_BIT-1:0] a, input logic [GF_BIT-1:0] b);
        logic [7:0] t;
        if (TOWER != 0) begin
            t = (GF_BIT == 8) ? t256_mul(8'(a), 8'(b)) : {4'h0, t16_mul(4'(a), 4'(b))};
            return t[GF_BIT-1:0];
        end
        return aes_mul(a, b);
    endfunction

    // a^(2^n-2) as the product of a^2, a^4, ... a^(2^(n-1)); yields 0 for a = 0
    function automatic logic [GF_BIT-1:0] gf_inv(input logic [GF_BIT-1:0] a);
        logic [GF_BIT-1:0] sq, res;
        sq  = a;
        res = GF_BIT'(1);
        for (int k = 1; k < GF_BIT; k++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    logic [LANES-1:0][GF_BIT-1:0] data_v, dataA_v, key_v;
    logic [LANES-1:0][GF_BIT-1:0] r_q, data_q, dataA_q;
    logic [LANES-1:0][GF_BIT-1:0] r_nxt, data_nxt, dataA_nxt;
    logic [GF_BIT-1:0]            dataB_nxt, d0;
    logic [1:0]                   gop_nxt;
    logic                         piv_found, piv_found_nxt, singular_nxt;
    logic [ROW_W-1:0]             row_cnt, row_cnt_nxt, pivot_row_nxt;

    assign data_v    = data_in;
    assign dataA_v   = dataA_in;
    assign key_v     = key_in;
    assign d0        = data_v[0];
    assign r         = r_q;
    assign data_out  = data_q;
    assign dataA_out = dataA_q;

    always_comb begin
        r_nxt         = r_q;
        data_nxt      = data_v;
        dataA_nxt     = dataA_v;
        dataB_nxt     = dataB_in;
        gop_nxt       = gauss_op_in;
        piv_found_nxt = piv_found;
        row_cnt_nxt   = row_cnt;
        pivot_row_nxt = pivot_row;
        singular_nxt  = singular;
        case (op_in)
            OP_KEY:   r_nxt = key_v;
            OP_SHIFT: begin
                r_nxt     = dataA_v;
                dataA_nxt = r_q;
            end
            OP_MACB:  for (int i = 0; i < LANES; i++) r_nxt[i] = r_q[i] ^ gf_mul(dataB_in, dataA_v[i]);
            OP_MACK:  for (int i = 0; i < LANES; i++) r_nxt[i] = r_q[i] ^ gf_mul(key_v[i], dataA_v[i]);
            OP_GAUSS: begin
                if (pivot_mode) begin
                    if (start_in) begin
                        piv_found_nxt = 1'b0;
                        row_cnt_nxt   = '0;
                        pivot_row_nxt = '0;
                        singular_nxt  = 1'b0;
                        r_nxt         = '0;
                        gop_nxt       = 2'b00;
                        dataB_nxt     = '0;
                        if (finish_in) begin
                            singular_nxt = 1'b1;
                            gop_nxt      = 2'b11;
                        end
                    end else if (finish_in) begin
                        gop_nxt      = 2'b11;
                        singular_nxt = !piv_found;
                        dataB_nxt    = '0;
                    end else begin
                        if (piv_found) begin
                            gop_nxt   = 2'b10;
                            dataB_nxt = d0;
                        end else if (d0 != '0) begin
                            piv_found_nxt = 1'b1;
                            pivot_row_nxt = row_cnt;
                            r_nxt[0]      = d0;
                            gop_nxt       = 2'b01;
                            dataB_nxt     = gf_inv(d0);
                        end else begin
                            gop_nxt   = 2'b00;
                            dataB_nxt = '0;
                        end
                        if (row_cnt != {ROW_W{1'b1}}) row_cnt_nxt = row_cnt + 1'b1;
                    end
                end else begin
                    for (int i = 0; i < LANES; i++) begin
                        if (start_in) begin
                            r_nxt[i]    = '0;
                            data_nxt[i] = '0;
                        end else begin
                            case (gauss_op_in)
                                2'b00: data_nxt[i] = data_v[i];
                                2'b01: begin
                                    r_nxt[i]    = gf_mul(dataB_in, data_v[i]);
                                    data_nxt[i] = r_q[i];
                                end
                                2'b10: data_nxt[i] = data_v[i] ^ gf_mul(dataB_in, r_q[i]);
                                default: begin
                                    data_nxt[i] = r_q[i];
                                    r_nxt[i]    = '0;
                                end
                            endcase
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out    <= 1'b0;
            start_out    <= 1'b0;
            finish_out   <= 1'b0;
            op_out       <= '0;
            gauss_op_out <= '0;
            data_q       <= '0;
            dataA_q      <= '0;
            dataB_out    <= '0;
            r_q          <= '0;
            pivot_row    <= '0;
            singular     <= 1'b0;
            piv_found    <= 1'b0;
            row_cnt      <= '0;
        end else if (en) begin
            valid_out  <= valid_in;
            start_out  <= valid_in & start_in;
            finish_out <= valid_in & finish_in;
            if (valid_in) begin
                op_out       <= op_in;
                gauss_op_out <= gop_nxt;
                data_q       <= data_nxt;
                dataA_q      <= dataA_nxt;
                dataB_out    <= dataB_nxt;
                r_q          <= r_nxt;
                pivot_row    <= pivot_row_nxt;
                singular     <= singular_nxt;
                piv_found    <= piv_found_nxt;
                row_cnt      <= row_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_gauss_pe_vec.sv
// Directed and randomised bench for gauss_pe_vec (GF16 AES x4 lanes, plus a GF256 single-lane pivot instance).
module tb_gauss_pe_vec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, pivot_mode, valid_in, start_in, finish_in;
    logic [3:0]  op_in, dataB_in;
    logic [1:0]  gauss_op_in;
    logic [15:0] data_in, dataA_in, key_in;
    logic [7:0]  dataB8_in;

    logic        valid_out, start_out, finish_out, singular;
    logic [3:0]  op_out, dataB_out;
    logic [1:0]  gauss_op_out;
    logic [15:0] data_out, dataA_out, r;
    logic [5:0]  pivot_row;

    logic        valid8_out, start8_out, finish8_out, singular8;
    logic [3:0]  op8_out;
    logic [1:0]  gauss_op8_out;
    logic [7:0]  data8_out, dataA8_out, dataB8_out, r8;
    logic [5:0]  pivot_row8;

    int vectors = 0;
    int miscompares = 0;

    gauss_pe_vec #(.GF_BIT(4), .LANES(4), .OP_CODE_LEN(4), .TOWER(0), .ROW_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pivot_mode(pivot_mode), .valid_in(valid_in),
        .valid_out(valid_out), .start_in(start_in), .start_out(start_out),
        .finish_in(finish_in), .finish_out(finish_out), .op_in(op_in), .op_out(op_out),
        .gauss_op_in(gauss_op_in), .gauss_op_out(gauss_op_out), .data_in(data_in),
        .data_out(data_out), .dataA_in(dataA_in), .dataA_out(dataA_out),
        .dataB_in(dataB_in), .dataB_out(dataB_out), .key_in(key_in), .r(r),
        .pivot_row(pivot_row), .singular(singular)
    );

    gauss_pe_vec #(.GF_BIT(8), .LANES(1), .OP_CODE_LEN(4), .TOWER(0), .ROW_W(6)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .pivot_mode(1'b1), .valid_in(valid_in),
        .valid_out(valid8_out), .start_in(start_in), .start_out(start8_out),
        .finish_in(finish_in), .finish_out(finish8_out), .op_in(op_in), .op_out(op8_out),
        .gauss_op_in(gauss_op_in), .gauss_op_out(gauss_op8_out), .data_in(data_in[7:0]),
        .data_out(data8_out), .dataA_in(dataA_in[7:0]), .dataA_out(dataA8_out),
        .dataB_in(dataB8_in), .dataB_out(dataB8_out), .key_in(key_in[7:0]), .r(r8),
        .pivot_row(pivot_row8), .singular(singular8)
    );

    // GF(16) reference arithmetic via discrete log tables of the generator x
    int exp_t[15];
    int log_t[16];
    int rm[4], dm[4], am[4], nr[4], nd[4], na[4], dv[4], av[4], kv[4];
    int bm;
    logic vm;
    int ops[8] = '{1, 1, 3, 4, 6, 7, 0, 9};

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 15];
    endfunction

    function automatic int ginv(input int a);
        if (a == 0) return 0;
        return exp_t[(15 - log_t[a]) % 15];
    endfunction

    function automatic int lane(input logic [15:0] v, input int i);
        return int'(v[4*i +: 4]);
    endfunction

    function automatic logic [15:0] pack4(input int a[4]);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) p[4*i +: 4] = a[i][3:0];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] op, input logic [1:0] gop, input logic st, input logic fi,
                        input logic [15:0] d, input logic [15:0] da, input logic [3:0] db,
                        input logic [15:0] k);
        en = 1'b1; valid_in = 1'b1; op_in = op; gauss_op_in = gop; start_in = st; finish_in = fi;
        data_in = d; dataA_in = da; dataB_in = db; key_in = k;
        cyc();
    endtask

    initial begin
        exp_t[0] = 1;
        for (int i = 1; i < 15; i++) begin
            exp_t[i] = exp_t[i-1] * 2;
            if (exp_t[i] >= 16) exp_t[i] = exp_t[i] ^ 'h13;
        end
        log_t[0] = 0;
        for (int i = 0; i < 15; i++) log_t[exp_t[i]] = i;

        rst_n = 1'b1; en = 1'b1; pivot_mode = 1'b0; valid_in = 1'b0; start_in = 1'b0;
        finish_in = 1'b0; op_in = '0; gauss_op_in = '0; data_in = '0; dataA_in = '0;
        dataB_in = '0; key_in = '0; dataB8_in = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_r", r, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_pivot_row", pivot_row, 0);
        chk("rst_singular", singular, 0);
        @(negedge clk) rst_n = 1'b1;

        // OP6 accumulate, freeze, async reset mid-accumulation
        beat(4'd6, 2'b00, 1'b0, 1'b0, 16'h0, 16'h8019, 4'd2, 16'h0);
        chk("op6_r", r, 16'h3021);
        chk("op6_dataA", dataA_out, 16'h8019);
        chk("op6_dataB", dataB_out, 4'd2);
        chk("op6_valid", valid_out, 1);
        en = 1'b0; dataA_in = 16'hFFFF; dataB_in = 4'd7; data_in = 16'h1111; op_in = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("freeze_r", r, 16'h3021);
        chk("freeze_dataA", dataA_out, 16'h8019);
        chk("freeze_dataB", dataB_out, 4'd2);
        chk("freeze_op", op_out, 4'd6);
        chk("freeze_data", data_out, 16'h0);
        beat(4'd6, 2'b00, 1'b0, 1'b0, 16'h0, 16'h8019, 4'd1, 16'h0);
        chk("op6_acc_r", r, 16'hB038);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_r", r, 0);
        chk("arst_valid", valid_out, 0);
        chk("arst_dataA", dataA_out, 0);
        chk("arst_op", op_out, 0);
        #2 rst_n = 1'b1;
        cyc();
        chk("post_arst_r", r, 16'h8019);

        // Pivot PE: start, 0, 2, 3, finish
        pivot_mode = 1'b1;
        beat(4'd1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        chk("piv_start_gop", gauss_op_out, 2'b00);
        chk("piv_start_dB", dataB_out, 0);
        beat(4'd1, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        chk("piv_z_gop", gauss_op_out, 2'b00);
        chk("piv_z_dB", dataB_out, 0);
        beat(4'd1, 2'b00, 1'b0, 1'b0, 16'h0002, 16'h0, 4'd0, 16'h0);
        chk("piv_found_gop", gauss_op_out, 2'b01);
        chk("piv_found_dB", dataB_out, ginv(2));
        chk("piv_found_r", r, 16'h0002);
        beat(4'd1, 2'b00, 1'b0, 1'b0, 16'h7003, 16'h0, 4'd0, 16'h0);
        chk("piv_after_gop", gauss_op_out, 2'b10);
        chk("piv_after_dB", dataB_out, 4'd3);
        chk("piv_pass_data", data_out, 16'h7003);
        beat(4'd1, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0, 4'd0, 16'h0);
        chk("piv_fin_gop", gauss_op_out, 2'b11);
        chk("piv_fin_row", pivot_row, 1);
        chk("piv_fin_sing", singular, 0);

        // Singular pass, then restart clears it; start+finish together
        beat(4'd1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        repeat (4) beat(4'd1, 2'b00, 1'b0, 1'b0, 16'hFFF0, 16'h0, 4'd0, 16'h0);
        beat(4'd1, 2'b00, 1'b0, 1'b1, 16'h0, 16'h0, 4'd0, 16'h0);
        chk("sing_set", singular, 1);
        chk("sing_row", pivot_row, 0);
        beat(4'd1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        chk("sing_clear", singular, 0);
        beat(4'd1, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0, 4'd0, 16'h0);
        chk("stfi_sing", singular, 1);
        chk("stfi_gop", gauss_op_out, 2'b11);

        // Row counter saturates at 63
        beat(4'd1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        repeat (70) beat(4'd1, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        beat(4'd1, 2'b00, 1'b0, 1'b0, 16'h0005, 16'h0, 4'd0, 16'h0);
        chk("sat_row", pivot_row, 63);
        chk("sat_dB", dataB_out, ginv(5));

        // GF256 AES inverse through the single-lane pivot instance
        beat(4'd1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        beat(4'd1, 2'b00, 1'b0, 1'b0, 16'h0053, 16'h0, 4'd0, 16'h0);
        chk("gf256_inv", dataB8_out, 8'hCA);
        chk("gf256_r", r8, 8'h53);

        // Elimination PE
        pivot_mode = 1'b0;
        beat(4'd1, 2'b00, 1'b1, 1'b0, 16'hFFFF, 16'h0, 4'd0, 16'h0);
        chk("elim_start_r", r, 0);
        chk("elim_start_d", data_out, 0);
        beat(4'd1, 2'b01, 1'b0, 1'b0, 16'h4321, 16'h0, 4'd1, 16'h0);
        chk("elim01_r", r, 16'h4321);
        chk("elim01_d", data_out, 0);
        beat(4'd1, 2'b10, 1'b0, 1'b0, 16'h0, 16'h0, 4'd3, 16'h0);
        chk("elim10_d", data_out, 16'hC563);
        chk("elim10_r", r, 16'h4321);
        valid_in = 1'b0; data_in = 16'h9999; gauss_op_in = 2'b11;
        cyc();
        chk("novalid_v", valid_out, 0);
        chk("novalid_r", r, 16'h4321);
        chk("novalid_d", data_out, 16'hC563);
        beat(4'd1, 2'b11, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        chk("elim11_d", data_out, 16'h4321);
        chk("elim11_r", r, 0);

        // Randomised elimination/MAC traffic against the table model
        beat(4'd1, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0, 4'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin rm[i] = 0; dm[i] = 0; am[i] = 0; end
        bm = 0; vm = 1'b1;
        for (int t = 0; t < 300; t++) begin
            en = ($urandom_range(0, 7) != 0);
            valid_in = ($urandom_range(0, 3) != 0);
            op_in = 4'(ops[$urandom_range(0, 7)]);
            gauss_op_in = 2'($urandom_range(0, 3));
            start_in = ($urandom_range(0, 7) == 0);
            finish_in = ($urandom_range(0, 7) == 0);
            data_in = 16'($urandom); dataA_in = 16'($urandom); key_in = 16'($urandom);
            dataB_in = 4'($urandom_range(0, 15));
            if (en) begin
                vm = valid_in;
                if (valid_in) begin
                    for (int i = 0; i < 4; i++) begin
                        dv[i] = lane(data_in, i); av[i] = lane(dataA_in, i); kv[i] = lane(key_in, i);
                        nr[i] = rm[i]; nd[i] = dv[i]; na[i] = av[i];
                    end
                    for (int i = 0; i < 4; i++) begin
                        case (op_in)
                            4'd3: nr[i] = kv[i];
                            4'd4: begin nr[i] = av[i]; na[i] = rm[i]; end
                            4'd6: nr[i] = rm[i] ^ gmul(int'(dataB_in), av[i]);
                            4'd7: nr[i] = rm[i] ^ gmul(kv[i], av[i]);
                            4'd1: begin
                                if (start_in) begin nr[i] = 0; nd[i] = 0; end
                                else if (gauss_op_in == 2'b01) begin nr[i] = gmul(int'(dataB_in), dv[i]); nd[i] = rm[i]; end
                                else if (gauss_op_in == 2'b10) nd[i] = dv[i] ^ gmul(int'(dataB_in), rm[i]);
                                else if (gauss_op_in == 2'b11) begin nd[i] = rm[i]; nr[i] = 0; end
                            end
                            default: ;
                        endcase
                    end
                    rm = nr; dm = nd; am = na; bm = int'(dataB_in);
                end
            end
            cyc();
            chk("rnd_r", r, pack4(rm));
            chk("rnd_data", data_out, pack4(dm));
            chk("rnd_dataA", dataA_out, pack4(am));
            chk("rnd_dataB", dataB_out, bm);
            chk("rnd_valid", valid_out, vm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
